seg7_capture: RTL and testbench

Return-path block for the seven-segment display interface: monitors a multiplexed, active-low segment bus plus active-low digit selects and converts each stable glyph back into a 4-bit hex nibble. It is the inverse of the team's nibble-to-segment decoder. It sits between the display driver outputs and the processor's debug/self-test logic, so the display path can be checked in loopback. Patterns are accepted only after they hold steady for a programmable number of cycles; unrecognised glyphs raise a per-digit error.

---
 rtl/seg7_capture.sv | 169 ++++++++++++++++
 tb/tb_seg7_capture.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// ============================================================================
// Module      : seg7_capture
// Description : Seven-segment return-path monitor. Debounces the multiplexed
//               active-low segment/digit-select bus and decodes each stable
//               glyph back to a hex nibble per digit position.
//               Optional sticky error mode: define SEG7_CAP_STICKY_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:6]            seg,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     valid,
  output logic [DIGITS-1:0]     err,
  output logic                  upd,
  output logic                  frame_done
`ifdef SEG7_CAP_STICKY_ERR_EN
  ,
  input  logic                  clr_err
`endif
);

  localparam logic [7:0] C_LAST = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HELD  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [0:6]          r_smp_seg;
  logic [DIGITS-1:0]   r_smp_sel;
  logic [7:0]          r_cnt;
  logic [7:0]          w_cnt_nxt;
  logic [DIGITS-1:0]   r_seen;
  logic [DIGITS-1:0]   w_act;
  logic [DIGITS-1:0]   w_seen_nxt;
  logic                w_match;
  logic                w_onehot;
  logic                w_capture;
  logic                w_legal;
  logic [3:0]          w_nib;

  // Active digit as a positive one-hot vector
  assign w_act      = ~dig_sel;
  assign w_onehot   = (w_act != '0) && ((w_act & (w_act - DIGITS'(1))) == '0);
  assign w_match    = (seg == r_smp_seg) && (dig_sel == r_smp_sel);
  assign w_seen_nxt = r_seen | w_act;

  always_comb begin
    w_legal = 1'b1;
    w_nib   = 4'h0;
    case (seg)
      7'b0000001: w_nib = 4'h0;
      7'b1001111: w_nib = 4'h1;
      7'b0010010: w_nib = 4'h2;
      7'b0000110: w_nib = 4'h3;
      7'b1001100: w_nib = 4'h4;
      7'b0100100: w_nib = 4'h5;
      7'b0100000: w_nib = 4'h6;
      7'b0001111: w_nib = 4'h7;
      7'b0000000: w_nib = 4'h8;
      7'b0000100: w_nib = 4'h9;
      7'b0001000: w_nib = 4'hA;
      7'b1100000: w_nib = 4'hB;
      7'b0110001: w_nib = 4'hC;
      7'b1000010: w_nib = 4'hD;
      7'b0110000: w_nib = 4'hE;
      7'b0111000: w_nib = 4'hF;
      default:    w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_smp_seg <= '1;
      r_smp_sel <= '1;
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
    end else begin
      r_smp_seg <= seg;
      r_smp_sel <= dig_sel;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  // HELD blocks re-capture, so cnt can never run past C_LAST
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    if (!(w_match && w_onehot)) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = COUNT;
          w_cnt_nxt   = 8'd1;
        end
        COUNT: begin
          if (r_cnt == C_LAST) begin
            w_capture   = 1'b1;
            w_state_nxt = HELD;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
        HELD:    w_state_nxt = HELD;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value      <= '0;
      valid      <= '0;
      err        <= '0;
      upd        <= 1'b0;
      frame_done <= 1'b0;
      r_seen     <= '0;
    end else begin
      upd        <= w_capture;
      frame_done <= 1'b0;
`ifdef SEG7_CAP_STICKY_ERR_EN
      if (clr_err) begin
        err <= '0;
      end
`endif
      // Capture updates come after the clear so a same-cycle capture wins
      if (w_capture) begin
        for (int d = 0; d < DIGITS; d++) begin
          if (w_act[d]) begin
            if (w_legal) begin
              value[4*d +: 4] <= w_nib;
              valid[d]        <= 1'b1;
`ifndef SEG7_CAP_STICKY_ERR_EN
              err[d]          <= 1'b0;
`endif
            end else begin
              valid[d] <= 1'b0;
              err[d]   <= 1'b1;
            end
          end
        end
        if (w_seen_nxt == '1) begin
          frame_done <= 1'b1;
          r_seen     <= '0;
        end else begin
          r_seen <= w_seen_nxt;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7_capture.sv
// ============================================================================
// Module      : tb_seg7_capture
// Description : Directed bench for seg7_capture with a run-length reference
//               model; honours SEG7_CAP_STICKY_ERR_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_capture;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] G1    = 7'b1001111;
  localparam logic [6:0] G2    = 7'b0010010;
  localparam logic [6:0] G3    = 7'b0000110;
  localparam logic [6:0] G5    = 7'b0100100;
  localparam logic [6:0] G7    = 7'b0001111;
  localparam logic [6:0] G8    = 7'b0000000;
  localparam logic [6:0] GF    = 7'b0111000;
  localparam logic [6:0] GBAD  = 7'b1111110;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [0:6]  seg = 7'b1111111;
  logic [3:0]  dig_sel = 4'hF;
  logic [15:0] value;
  logic [3:0]  valid;
  logic [3:0]  err;
  logic        upd;
  logic        frame_done;
`ifdef SEG7_CAP_STICKY_ERR_EN
  logic        clr_err = 1'b0;
`endif

  always #5 clk = ~clk;

  seg7_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk        (clk),
    .reset      (reset),
    .seg        (seg),
    .dig_sel    (dig_sel),
    .value      (value),
    .valid      (valid),
    .err        (err),
    .upd        (upd),
    .frame_done (frame_done)
`ifdef SEG7_CAP_STICKY_ERR_EN
    ,
    .clr_err    (clr_err)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: a capture happens on the edge where a one-hot pattern
  // has been seen on STABLE+1 consecutive edges (first edge loads the sampler).
  logic [6:0]  glyph [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  logic [15:0] m_value = '0;
  logic [3:0]  m_valid = '0;
  logic [3:0]  m_err   = '0;
  logic [3:0]  m_seen  = '0;
  logic        m_upd   = 1'b0;
  logic        m_fd    = 1'b0;
  logic [10:0] m_prev  = '1;
  int          m_run   = 0;
  logic [3:0]  m_act;
  int          m_dg;
  int          m_nib;

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (glyph[i] == p) return i;
    return -1;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_value = '0; m_valid = '0; m_err = '0; m_seen = '0;
        m_upd = 1'b0; m_fd = 1'b0; m_prev = '1; m_run = 0;
      end else begin
        m_upd = 1'b0;
        m_fd  = 1'b0;
`ifdef SEG7_CAP_STICKY_ERR_EN
        if (clr_err) m_err = '0;
`endif
        if ({seg, dig_sel} == m_prev) m_run = (m_run < 1000) ? m_run + 1 : m_run;
        else m_run = 1;
        m_prev = {seg, dig_sel};
        m_act  = ~dig_sel;
        if (m_run == STABLE + 1 && $countones(m_act) == 1) begin
          m_dg = 0;
          for (int i = 0; i < DIGITS; i++) if (m_act[i]) m_dg = i;
          m_nib = lookup(seg);
          m_upd = 1'b1;
          if (m_nib >= 0) begin
            m_value[4*m_dg +: 4] = m_nib[3:0];
            m_valid[m_dg] = 1'b1;
`ifndef SEG7_CAP_STICKY_ERR_EN
            m_err[m_dg] = 1'b0;
`endif
          end else begin
            m_valid[m_dg] = 1'b0;
            m_err[m_dg]   = 1'b1;
          end
          m_seen[m_dg] = 1'b1;
          if (m_seen == 4'hF) begin
            m_fd   = 1'b1;
            m_seen = '0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("model_value", 32'(value), 32'(m_value));
        chk("model_valid", 32'(valid), 32'(m_valid));
        chk("model_err", 32'(err), 32'(m_err));
        chk("model_upd", 32'(upd), 32'(m_upd));
        chk("model_frame_done", 32'(frame_done), 32'(m_fd));
      end
    end
  end

  // Applies a pattern at a falling edge and keeps it for n rising edges
  task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n,
                      output int fu, output int nu, output int ffd, output int nfd);
    seg = s; dig_sel = d;
    fu = 0; nu = 0; ffd = 0; nfd = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (upd) begin
        nu++;
        if (fu == 0) fu = k;
      end
      if (frame_done) begin
        nfd++;
        if (ffd == 0) ffd = k;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fu, nu, ffd, nfd, fd_total;

    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({value, valid, err, upd, frame_done}), 32'd0);
    reset = 1'b0;
    hold(BLANK, 4'hF, 2, fu, nu, ffd, nfd);

    hold(G2, 4'b1110, 6, fu, nu, ffd, nfd);
    chk("single_upd_latency", 32'(fu), 32'd5);
    chk("single_upd_count", 32'(nu), 32'd1);
    chk("single_value", 32'(value[3:0]), 32'h2);
    chk("single_valid", 32'(valid), 32'b0001);
    hold(BLANK, 4'hF, 2, fu, nu, ffd, nfd);

    hold(G5, 4'b1110, 3, fu, nu, ffd, nfd);
    chk("glitch_pre_upd", 32'(nu), 32'd0);
    hold(7'b0100101, 4'b1110, 1, fu, nu, ffd, nfd);
    chk("glitch_cycle_upd", 32'(nu), 32'd0);
    hold(G5, 4'b1110, 6, fu, nu, ffd, nfd);
    chk("glitch_restart_latency", 32'(fu), 32'd5);
    chk("glitch_value", 32'(value[3:0]), 32'h5);

    hold(G7, 4'b1011, 6, fu, nu, ffd, nfd);
    chk("digit2_value", 32'(value[11:8]), 32'h7);
    hold(GBAD, 4'b1011, 6, fu, nu, ffd, nfd);
    chk("illegal_upd_count", 32'(nu), 32'd1);
    chk("illegal_err2", 32'(err[2]), 32'd1);
    chk("illegal_valid2", 32'(valid[2]), 32'd0);
    chk("illegal_value_kept", 32'(value[11:8]), 32'h7);

    hold(G3, 4'b1101, STABLE - 1, fu, nu, ffd, nfd);
    hold(BLANK, 4'hF, 2, fu, nu, ffd, nfd);
    chk("short_hold_no_upd", 32'(nu), 32'd0);
    hold(G3, 4'b1001, 6, fu, nu, ffd, nfd);
    chk("multi_zero_no_upd", 32'(nu), 32'd0);
    hold(BLANK, 4'hF, 1, fu, nu, ffd, nfd);

    hold(G3, 4'b1101, 3, fu, nu, ffd, nfd);
    #2 reset = 1'b1;
    seg = BLANK; dig_sel = 4'hF;
    #1 chk("async_reset_outputs", 32'({value, valid, err, upd, frame_done}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    hold(BLANK, 4'hF, STABLE, fu, nu, ffd, nfd);
    chk("no_upd_after_reset", 32'(nu), 32'd0);

    fd_total = 0;
    hold(G1, 4'b1110, 6, fu, nu, ffd, nfd); fd_total += nfd;
    hold(G2, 4'b1101, 6, fu, nu, ffd, nfd); fd_total += nfd;
    hold(G3, 4'b1011, 6, fu, nu, ffd, nfd); fd_total += nfd;
    chk("frame_no_early_done", 32'(fd_total), 32'd0);
    hold(GF, 4'b0111, 6, fu, nu, ffd, nfd); fd_total += nfd;
    chk("frame_done_once", 32'(fd_total), 32'd1);
    chk("frame_done_with_upd", 32'(ffd), 32'(fu));
    chk("frame_value", 32'(value), 32'hF321);
    chk("frame_valid", 32'(valid), 32'hF);

    hold(BLANK, 4'hF, 2, fu, nu, ffd, nfd);
    hold(GBAD, 4'b1110, 6, fu, nu, ffd, nfd);
    chk("err0_set", 32'(err[0]), 32'd1);
    hold(G8, 4'b1110, 6, fu, nu, ffd, nfd);
    chk("legal_after_err_value", 32'(value[3:0]), 32'h8);
    chk("legal_after_err_valid", 32'(valid[0]), 32'd1);
`ifdef SEG7_CAP_STICKY_ERR_EN
    chk("sticky_err0_held", 32'(err[0]), 32'd1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("sticky_err0_cleared", 32'(err[0]), 32'd0);
`else
    chk("nonsticky_err0_cleared", 32'(err[0]), 32'd0);
`endif
    hold(BLANK, 4'hF, 2, fu, nu, ffd, nfd);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
